// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Combinational lookup feeds the PC register; the EX stage writes resolved branches back one cycle after resolution.
module branch_predictor #(
    parameter int IDX_BITS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC_IF,
    input  logic        UPD_EN,
    input  logic [31:0] UPD_PC,
    input  logic        UPD_TAKEN,
    input  logic [31:0] UPD_TARGET,
    output logic        PRED_TAKEN,
    output logic [31:0] PRED_TARGET,
    output logic [31:0] NEXT_PC,
    output logic [31:0] HIT_CNT,
    output logic [31:0] UPD_CNT
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 30 - IDX_BITS;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [31:0]        targets [ENTRIES];
    logic [1:0]         ctrs    [ENTRIES];
    logic [31:0]        hit_cnt;
    logic [31:0]        upd_cnt;

    logic [IDX_BITS-1:0] look_idx;
    logic [TAG_W-1:0]    look_tag;
    logic                look_hit;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;

    // Byte offset bits never take part in indexing or tagging.
    logic unused_ok;
    assign unused_ok = &{1'b0, PC_IF[1:0], UPD_PC[1:0]};

    assign look_idx = PC_IF[IDX_BITS+1:2];
    assign look_tag = PC_IF[31:IDX_BITS+2];
    assign look_hit = valid[look_idx] && (tags[look_idx] == look_tag);

    assign upd_idx  = UPD_PC[IDX_BITS+1:2];
    assign upd_tag  = UPD_PC[31:IDX_BITS+2];
    assign upd_hit  = valid[upd_idx] && (tags[upd_idx] == upd_tag);

    // Read-before-write: the lookup sees table contents prior to this cycle's update.
    assign PRED_TAKEN  = look_hit && ctrs[look_idx][1];
    assign PRED_TARGET = look_hit ? targets[look_idx] : 32'd0;
    assign NEXT_PC     = PRED_TAKEN ? PRED_TARGET : PC_IF + 32'd4;
    assign HIT_CNT     = hit_cnt;
    assign UPD_CNT     = upd_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i]   <= 1'b0;
                tags[i]    <= '0;
                targets[i] <= '0;
                ctrs[i]    <= 2'b01;
            end
            hit_cnt <= '0;
            upd_cnt <= '0;
        end else if (UPD_EN) begin
            upd_cnt <= upd_cnt + 32'd1;
            if (upd_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
                if (UPD_TAKEN) begin
                    if (ctrs[upd_idx] != 2'b11) ctrs[upd_idx] <= ctrs[upd_idx] + 2'b01;
                    targets[upd_idx] <= UPD_TARGET;
                end else if (ctrs[upd_idx] != 2'b00) begin
                    ctrs[upd_idx] <= ctrs[upd_idx] - 2'b01;
                end
            end else if (UPD_TAKEN) begin
                // Taken miss replaces whatever occupies the slot, starting weakly taken.
                valid[upd_idx]   <= 1'b1;
                tags[upd_idx]    <= upd_tag;
                targets[upd_idx] <= UPD_TARGET;
                ctrs[upd_idx]    <= 2'b10;
            end
        end
    end
endmodule
